// File: rtl/counter_pkg.sv
// Shared constants for the bus-attached program/address counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_pkg;

  // Native datapath width of the CPU; the counter and its bus driver default to it.
  localparam int COUNTER_DEFAULT_WIDTH = 32;

endpackage : counter_pkg

// File: rtl/counter_tristate_buffer.sv
// Generic bus driver: drives its input onto a shared tri-state bus while enabled.
// Latency: purely combinational, zero cycles for both drive and release.
// Backpressure: none; contention is avoided by enabling one driver per bus at a time.
module tristate_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output tri   [WIDTH-1:0] out
);

  // Release the bus to high impedance whenever this driver is not selected.
  assign out = en ? in : {WIDTH{1'bz}};

endmodule : tristate_buffer

// File: rtl/counter.sv
// Loadable up-counter whose value is driven onto a shared bus under output enable.
// Latency: load/increment take effect at the next rising edge; oe to out is combinational.
// Backpressure: none; one action per edge chosen by priority reset > load > increment > hold.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt,
  input  logic             ld,
  input  logic             oe,
  input  logic [WIDTH-1:0] in,
  output tri   [WIDTH-1:0] out
);

  logic [WIDTH-1:0] value;

  // Reset wins over load, load wins over increment (no +1 on a load); increment wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (ld) begin
      value <= in;
    end else if (cnt) begin
      value <= value + WIDTH'(1);
    end
  end

  tristate_buffer #(
    .WIDTH(WIDTH)
  ) u_bus_drv (
    .en (oe),
    .in (value),
    .out(out)
  );

endmodule : counter

// File: tb/tb_counter.sv
// Self-checking bench for the counter: directed cases followed by random traffic.
// Latency: expects results one edge after the inputs are applied.
// Backpressure: n/a.
module tb_counter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cnt = 1'b0;
  logic         ld  = 1'b0;
  logic         oe  = 1'b0;
  logic [W-1:0] din = '0;
  tri   [W-1:0] bus;

  // Second driver on the bus; a released DUT lets this pattern through untouched.
  logic         probe_en  = 1'b0;
  logic [W-1:0] probe_pat = '0;
  assign bus = probe_en ? probe_pat : {W{1'bz}};

  int vectors     = 0;
  int miscompares = 0;

  // Reference value of the counter, derived from the operation rules.
  logic [W-1:0] model = '0;

  always #5 clk = ~clk;

  counter #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cnt(cnt),
    .ld (ld),
    .oe (oe),
    .in (din),
    .out(bus)
  );

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // With oe high the bus must show the count; with oe low the DUT must not fight the probe.
  task automatic verify_bus(input string tag);
    if (oe === 1'b1) begin
      check_val(tag, bus, model);
    end else begin
      probe_pat = ~model;
      probe_en  = 1'b1;
      #1;
      check_val({tag, "_released"}, bus, ~model);
      probe_en  = 1'b0;
      #1;
    end
  endtask

  // Apply one set of controls across a single rising edge and check the result.
  task automatic step(input logic r, input logic l, input logic c, input logic o,
                      input logic [W-1:0] d, input string tag);
    longint next_val;
    @(negedge clk);
    rst = r; ld = l; cnt = c; oe = o; din = d;
    @(posedge clk);
    if (r === 1'b1) begin
      next_val = 0;
    end else if (l === 1'b1) begin
      next_val = longint'(d);
    end else if (c === 1'b1) begin
      next_val = (longint'(model) + 1) % (longint'(1) << W);
    end else begin
      next_val = longint'(model);
    end
    model = W'(next_val);
    #1;
    verify_bus(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic         r, l, c, o;
    logic [W-1:0] d;

    // Reset then count.
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, "reset");
    check_val("reset_zero", bus, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0, "count1");
    check_val("count1_abs", bus, 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0, "count2");
    check_val("count2_abs", bus, 32'h2);

    // Load beats count, then wrap.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, "ld_beats_cnt");
    check_val("ld_beats_cnt_abs", bus, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 1'b1, 1'b1, '0, "wrap");
    check_val("wrap_abs", bus, 32'h0);

    // Hold for three edges from 5.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd5, "load5");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, "hold");
      check_val("hold_abs", bus, 32'd5);
    end

    // Reset overrides load and count.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd7, "load7");
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'd9, "rst_prio");
    check_val("rst_prio_abs", bus, 32'h0);

    // Unknown increment enable during reset must not leak into the value.
    step(1'b1, 1'b0, 1'bx, 1'b1, '0, "rst_cnt_x");

    // Output enable: release, then drive and release again with no edge.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_ABCD, "load_oe");
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, "oe_off");
    @(negedge clk);
    oe = 1'b1;
    #1;
    check_val("oe_drive_no_edge", bus, 32'h1234_ABCD);
    oe = 1'b0;
    #1;
    verify_bus("oe_release_no_edge");
    oe = 1'b1;

    // Control pulses between edges are ignored.
    @(negedge clk);
    cnt = 1'b1;
    #1;
    cnt = 1'b0;
    ld  = 1'b1;
    din = 32'h5555_5555;
    #1;
    ld  = 1'b0;
    @(posedge clk);
    #1;
    verify_bus("glitch_ignored");

    // Consecutive increments advance by the number of edges.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, "load_run");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b1, '0, "run");
    check_val("run_abs", bus, 32'h0000_0004);

    // Random traffic, biased towards values near the wrap point.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      else d = W'($urandom);
      step(r, l, c, o, d, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_counter
